// File: rtl/pipe_pkg.sv
// pipe_pkg: helpers shared by the pipe_* stream blocks.
//   keep_mask(cnt) : thermometer mask with ones in bits 0..cnt, zero above.
//                    Returned KEEP_MAX_W bits wide; callers slice the low lanes.
package pipe_pkg;

  // Widest lane count any pipe_* block may use.
  localparam int KEEP_MAX_W = 64;

  function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int cnt);
    logic [KEEP_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX_W; i++)
      if (i <= cnt) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_width_packer.sv
// pipe_width_packer: valid/ready width upsizer. It packs RATIO consecutive
// DWIDTH-bit beats into one RATIO*DWIDTH-bit word, with lane 0 in the LSBs.
// A beat with i_last flushes a partial word early. o_keep marks the filled
// lanes of that word.
//
// Ports
//   clk, rstn         clock, async active-low reset
//   i_data/i_valid/i_last, o_ready    narrow input stream
//   o_data/o_keep/o_last/o_valid, i_ready  wide output stream
//
// i_ready comes from a downstream skid buffer with a registered ready, so
// o_ready = !o_valid || i_ready does not form a long combinational chain.
module pipe_width_packer
  import pipe_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DWIDTH-1:0]       i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic [RATIO*DWIDTH-1:0] o_data,
  output logic [RATIO-1:0]        o_keep,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(RATIO - 1);

  // Lanes 0..RATIO-2 are buffered. The top lane never needs storage because
  // the beat that fills it always completes the word.
  logic [RATIO-2:0][DWIDTH-1:0] acc_data;
  logic [CNT_W-1:0]             acc_cnt;

  logic                         accept;
  logic                         complete;
  logic [RATIO-1:0][DWIDTH-1:0] word_nxt;
  logic [KEEP_MAX_W-1:0]        keep_full;

  // The output register is empty or drains this cycle.
  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  assign complete = accept && ((acc_cnt == CNT_TOP) || i_last);

  // Assemble the outgoing word. Lanes below acc_cnt come from the
  // accumulator, lane acc_cnt takes the incoming beat, and higher lanes are
  // zero.
  for (genvar k = 0; k < RATIO - 1; k++) begin : g_lane
    always_comb begin
      word_nxt[k] = '0;
      if (acc_cnt == CNT_W'(k))
        word_nxt[k] = i_data;
      else if (acc_cnt > CNT_W'(k))
        word_nxt[k] = acc_data[k];
    end
  end

  assign word_nxt[RATIO-1] = (acc_cnt == CNT_TOP) ? i_data : '0;

  assign keep_full = keep_mask(int'(acc_cnt));

  // Accumulator
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_cnt  <= '0;
      acc_data <= '0;
    end else if (complete) begin
      acc_cnt  <= '0;
      acc_data <= '0;
    end else if (accept) begin
      for (int k = 0; k < RATIO - 1; k++)
        if (acc_cnt == CNT_W'(k)) acc_data[k] <= i_data;
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // Output register. On a simultaneous drain and completion it reloads, so
  // o_valid stays high. On a plain drain only o_valid drops. The payload
  // holds its last value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
    end else if (complete) begin
      o_valid <= 1'b1;
      o_data  <= word_nxt;
      o_keep  <= keep_full[RATIO-1:0];
      o_last  <= i_last;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_width_packer.sv
module tb_pipe_width_packer;
  localparam int DW = 8;
  localparam int R  = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [DW-1:0]   i_data = '0;
  logic            i_valid = 1'b0;
  logic            i_last = 1'b0;
  logic            o_ready;
  logic [R*DW-1:0] o_data;
  logic [R-1:0]    o_keep;
  logic            o_last;
  logic            o_valid;
  logic            i_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 0;

  pipe_width_packer #(.DWIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep),
    .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the accepted beats form a packet list, and each group of
  // R beats or each beat up to an i_last becomes one expected word.
  typedef struct {
    logic [R*DW-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] part[$];

  logic [R*DW-1:0] hold_data;
  logic [R-1:0]    hold_keep;
  logic            hold_last;
  bit              stall_prev = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      part.delete();
      stall_prev = 0;
    end else begin
      chk("o_ready_rule", 64'(o_ready), 64'(!o_valid || i_ready));
      if (stall_prev) begin
        chk("stall_data", 64'(o_data), 64'(hold_data));
        chk("stall_keep", 64'(o_keep), 64'(hold_keep));
        chk("stall_last", 64'(o_last), 64'(hold_last));
        chk("stall_valid", 64'(o_valid), 64'd1);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word got=%h want=none", o_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_data", 64'(o_data), 64'(w.data));
          chk("word_keep", 64'(o_keep), 64'(w.keep));
          chk("word_last", 64'(o_last), 64'(w.last));
        end
      end
      if (i_valid && o_ready) begin
        part.push_back(i_data);
        if (part.size() == R || i_last) begin
          word_t w;
          w.data = '0;
          for (int i = 0; i < part.size(); i++) w.data[i*DW +: DW] = part[i];
          w.keep = R'((1 << part.size()) - 1);
          w.last = i_last;
          exp_q.push_back(w);
          part.delete();
        end
      end
      stall_prev = o_valid && !i_ready;
      hold_data = o_data; hold_keep = o_keep; hold_last = o_last;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    int  n;
    logic acc;
    n = 0;
    i_valid = 1'b1; i_data = d; i_last = l;
    forever begin
      if (rand_mode) i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout got=stalled want=accept");
        break;
      end
    end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  64'(o_data),  64'd0);
    chk("rst_keep",  64'(o_keep),  64'd0);
    chk("rst_last",  64'(o_last),  64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    chk("init_valid", 64'(o_valid), 64'd0);
    chk("init_data",  64'(o_data),  64'd0);
    chk("init_keep",  64'(o_keep),  64'd0);
    chk("init_last",  64'(o_last),  64'd0);
    chk("init_ready", 64'(o_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset while a held word is present.
    i_ready = 1'b0;
    send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
    chk("held_valid", 64'(o_valid), 64'd1);
    pulse_reset();

    // Reset with a partial word.
    i_ready = 1'b1;
    send(8'h77, 0); send(8'h78, 0);
    pulse_reset();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("post_rst_valid", 64'(o_valid), 64'd1);
    chk("post_rst_data",  64'(o_data),  64'h44332211);

    // Back-to-back streaming.
    for (int b = 1; b <= 8; b++) begin
      send(DW'(b), 0);
      chk("stream_ready", 64'(o_ready), 64'd1);
      if (b == 4) begin
        chk("stream_w0", 64'(o_data), 64'h04030201);
        chk("stream_k0", 64'(o_keep), 64'hF);
      end
    end
    chk("stream_w1", 64'(o_data), 64'h08070605);
    chk("stream_k1", 64'(o_keep), 64'hF);

    // Early flush, then the next beat goes into lane 0.
    send(8'hAA, 0); send(8'hBB, 1);
    chk("flush_data", 64'(o_data), 64'h0000BBAA);
    chk("flush_keep", 64'(o_keep), 64'h3);
    chk("flush_last", 64'(o_last), 64'd1);
    send(8'hCC, 0); send(8'hDD, 1);
    chk("flush2_data", 64'(o_data), 64'h0000DDCC);

    // Single-beat packet, then drain and completion in the same cycle.
    send(8'h5A, 1);
    chk("single_data", 64'(o_data), 64'h0000005A);
    chk("single_keep", 64'(o_keep), 64'h1);
    chk("single_last", 64'(o_last), 64'd1);
    send(8'h5B, 1);
    chk("dc_valid", 64'(o_valid), 64'd1);
    chk("dc_data",  64'(o_data),  64'h0000005B);

    // Backpressure.
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h91;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 64'(o_ready), 64'd0);
      chk("bp_data",  64'(o_data),  64'hB4B3B2B1);
      chk("bp_keep",  64'(o_keep),  64'hF);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    send(8'h91, 0); send(8'h92, 0); send(8'h93, 0); send(8'h94, 0);
    chk("bp_resume", 64'(o_data), 64'h94939291);

    // Randomized traffic against the model.
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      send(DW'($urandom), (n == 399) || ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 5) == 0) begin
        i_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    rand_mode = 0;
    i_ready = 1'b1;
    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 50) begin
        @(posedge clk); #1; n++;
      end
    end
    @(negedge clk);
    chk("end_exp_empty",  64'(exp_q.size()), 64'd0);
    chk("end_part_empty", 64'(part.size()),  64'd0);
    chk("end_valid",      64'(o_valid),      64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
